bit_write_arbiter: RTL and testbench

Round-robin write arbiter and sequencer for a single shared one-bit storage cell. Up to N requesters each present a write request and a data bit. The block grants one requester at a time, drives the cell's write enable and data for exactly one cycle, and returns a one-cycle acknowledge to the winner. It owns the cell instance, so the stored bit is available to every requester on `q`.

---
 rtl/bit_arb_pkg.sv | 12 +
 rtl/bit_write_arbiter_cell.sv | 16 +
 rtl/bit_write_arbiter.sv | 83 ++++++++
 tb/tb_bit_write_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bit_arb_pkg.sv
// bit_arb_pkg: shared state encoding and defaults for the bit write arbiter
package bit_arb_pkg;

   localparam int N_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/bit_write_arbiter_cell.sv
// bit_cell: enable D flip-flop holding the shared bit, async reset to 0
module bit_cell (
   input  logic clk,
   input  logic reset,
   input  logic we,
   input  logic d,
   output logic q
);

   // capture d only on write-enabled edges, otherwise hold
   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= 1'b0;
      else if (we) q <= d;
   end

endmodule

// File: rtl/bit_write_arbiter.sv
// bit_write_arbiter: round-robin sequencer granting one-cycle writes to a shared bit cell
module bit_write_arbiter
   import bit_arb_pkg::*;
#(
   parameter int N   = N_DEFAULT,
   parameter int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   din,
   output logic [N-1:0]   ack,
   output logic           we,
   output logic           wdata,
   output logic [IDW-1:0] grant_id,
   output logic           busy,
   output logic           q
);

   localparam logic [N-1:0]   ONE  = N'(1);
   localparam logic [IDW-1:0] LAST = IDW'(N - 1);

   state_t           state_q;
   logic [IDW-1:0]   ptr_q;
   logic [IDW-1:0]   gid_q;
   logic             wdata_q;
   logic [2*N-1:0]   dbl;
   logic [N-1:0]     rot;
   logic [IDW-1:0]   enc;
   logic [IDW:0]     sum;
   logic [IDW-1:0]   win;

   // rotate requests so ptr sits at bit 0, pick lowest set bit, then rotate the index back
   always_comb begin
      dbl = {req, req} >> ptr_q;
      rot = dbl[N-1:0];
      enc = '0;
      for (int i = N - 1; i >= 0; i--)
         if (rot[i]) enc = IDW'(i);
      sum = {1'b0, ptr_q} + {1'b0, enc};
      win = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : IDW'(sum);
   end

   // IDLE -> WRITE -> DONE sequencer; winner and its data are frozen at grant
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         wdata_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE:
               if (|req) begin
                  gid_q   <= win;
                  wdata_q <= din[win];
                  state_q <= WRITE;
               end
            WRITE: state_q <= DONE;
            DONE: begin
               ptr_q   <= (gid_q == LAST) ? '0 : gid_q + IDW'(1);
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign we       = (state_q == WRITE);
   assign ack      = (state_q == DONE) ? (ONE << gid_q) : '0;
   assign busy     = (state_q != IDLE);
   assign grant_id = gid_q;
   assign wdata    = wdata_q;

   bit_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .d     (wdata_q),
      .q     (q)
   );

endmodule

// File: tb/tb_bit_write_arbiter.sv
// tb_bit_write_arbiter: directed scoreboard bench for the round-robin bit write arbiter
module tb_bit_write_arbiter;

   localparam int N   = 4;
   localparam int IDW = 2;

   typedef struct {
      int   id;
      logic d;
   } txn_t;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N-1:0]   din = '0;
   logic [N-1:0]   ack;
   logic           we;
   logic           wdata;
   logic [IDW-1:0] grant_id;
   logic           busy;
   logic           q;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   txn_t sb[$];

   bit_write_arbiter #(.N(N)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .din      (din),
      .ack      (ack),
      .we       (we),
      .wdata    (wdata),
      .grant_id (grant_id),
      .busy     (busy),
      .q        (q)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int id, input logic d);
      txn_t t;
      t.id = id;
      t.d  = d;
      sb.push_back(t);
   endtask

   // advance until an ack appears (bounded), then compare it against the oldest expected write
   task automatic wait_ack(input string tag);
      int   n = 0;
      txn_t t;
      do begin
         tick();
         n++;
      end while (ack == '0 && n < 20);
      chk({tag, "_timeout"}, 32'(n < 20), 32'd1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'(ack), 32'd0);
         return;
      end
      t = sb.pop_front();
      chk({tag, "_ack"}, 32'(ack), 32'(4'b0001 << t.id));
      chk({tag, "_gid"}, 32'(grant_id), 32'(t.id));
      chk({tag, "_q"}, 32'(q), 32'(t.d));
   endtask

   initial begin
      int last;
      int first;
      // reset state
      #1;
      chk("rst_async", 32'({busy, we, wdata, ack, grant_id, q}), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      chk("rst_out", 32'({busy, we, wdata, ack, grant_id, q}), 32'd0);
      // no requests: stays idle
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle", 32'({busy, we, ack, q}), 32'd0);
      end
      // single write from requester 2, data changes after grant are ignored
      req = 4'b0100;
      din = 4'b0100;
      push(2, 1'b1);
      tick();
      chk("t2_we", 32'(we), 32'd1);
      chk("t2_busy", 32'(busy), 32'd1);
      chk("t2_gid", 32'(grant_id), 32'd2);
      chk("t2_q_pre", 32'(q), 32'd0);
      din = 4'b0000;
      wait_ack("t2");
      chk("t2_we_off", 32'(we), 32'd0);
      req = 4'b0000;
      tick();
      chk("t2_idle", 32'({busy, ack}), 32'd0);
      chk("t2_q_hold", 32'(q), 32'd1);
      // reset pointer, then all requesters held
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t3_rst_q", 32'(q), 32'd0);
      req = 4'b1111;
      din = 4'b0101;
      push(0, 1'b1);
      push(1, 1'b0);
      push(2, 1'b1);
      push(3, 1'b0);
      push(0, 1'b1);
      first = 0;
      last = 0;
      for (int i = 0; i < 5; i++) begin
         wait_ack("t3_rr");
         if (i == 0) first = cyc;
         else chk("t3_gap", 32'(cyc - last), 32'd3);
         last = cyc;
      end
      chk("t3_period", 32'(last - first), 32'd12);
      req = 4'b0000;
      // grant to 1 so the pointer lands on 2
      tick();
      req = 4'b0010;
      din = 4'b0010;
      push(1, 1'b1);
      wait_ack("t4_pre");
      req = 4'b0000;
      tick();
      // requesters 1 and 3 together: 3 wins under ptr=2, then 1
      req = 4'b1010;
      din = 4'b0010;
      push(3, 1'b0);
      push(1, 1'b1);
      wait_ack("t4_first");
      req = 4'b0010;
      wait_ack("t4_second");
      req = 4'b0000;
      tick();
      // reset during a write of 1
      req = 4'b0100;
      din = 4'b0100;
      tick();
      chk("t5_we", 32'({we, wdata, q}), 32'b111);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_async", 32'({busy, we, wdata, ack, grant_id, q}), 32'd0);
      req = 4'b0000;
      tick();
      chk("t5_noack", 32'({busy, ack, q}), 32'd0);
      reset = 1'b0;
      // pointer restarted at 0: 1 beats 3
      req = 4'b1010;
      din = 4'b1000;
      push(1, 1'b0);
      push(3, 1'b1);
      wait_ack("t5_first");
      req = 4'b1000;
      wait_ack("t5_second");
      req = 4'b0000;
      tick();
      chk("t5_idle", 32'({busy, ack}), 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
